// File: rtl/spike_rate_monitor_pkg.sv
// Shared types and constants for the LIF network spike-rate monitor.
package lif_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } mon_state_e;

    localparam int NUM_CH = 4;

    // Channel indices: three input neurons, then the output neuron
    localparam int CH_N1  = 0;
    localparam int CH_N2  = 1;
    localparam int CH_N3  = 2;
    localparam int CH_OUT = 3;

endpackage

// File: rtl/spike_rate_monitor_if.sv
// Spike inputs, run controls and latched readout of the spike-rate monitor.
interface spike_rate_monitor_if #(
    parameter int CNT_W = 8
);
    import lif_mon_pkg::*;

    logic [NUM_CH-1:0] spike_in;
    logic              enable;
    logic              continuous;
    logic [1:0]        sel;
    logic [CNT_W-1:0]  count_out;
    logic [NUM_CH-1:0] sat_out;
    logic [1:0]        winner;
    logic              winner_valid;
    logic              window_done;
    logic              busy;

    // Network side / host side that drives spikes and controls
    modport master (
        output spike_in, enable, continuous, sel,
        input  count_out, sat_out, winner, winner_valid, window_done, busy
    );

    // The monitor itself
    modport slave (
        input  spike_in, enable, continuous, sel,
        output count_out, sat_out, winner, winner_valid, window_done, busy
    );

endinterface

// File: rtl/spike_rate_monitor_edge_counter.sv
// One channel: rising-edge detector feeding a saturating live counter
// with a sticky saturation flag. next_count/next_sat include this
// cycle's increment so the parent can latch them on the terminal cycle.
module spike_edge_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] next_count,
    output logic             next_sat
);

    logic             prev;
    logic [CNT_W-1:0] count;
    logic             sat;
    logic             hit;

    // Next live value: add one on a counted rising edge, flag overflow
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit        = spike & ~prev & cnt_en;
        next_count = count;
        next_sat   = sat;
        if (hit) begin
            if (count == '1) begin
                next_sat = 1'b1;
            end else begin
                next_count = count + 1'b1;
            end
        end
    end

    // prev tracks the input in every state; live state cleared on clr
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            prev  <= 1'b0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            prev <= spike;
            if (clr) begin
                count <= '0;
                sat   <= 1'b0;
            end else begin
                count <= next_count;
                sat   <= next_sat;
            end
        end
    end

endmodule

// File: rtl/spike_rate_monitor.sv
// Counts spike rising edges per channel over a fixed window, latches the
// counts, saturation flags and the busiest input neuron, and pulses
// window_done after each latch.
module spike_rate_monitor #(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_W      = 8
) (
    input logic                 clk,
    input logic                 reset,
    spike_rate_monitor_if.slave mon
);
    import lif_mon_pkg::*;

    localparam int              WIN_W    = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);

    mon_state_e        state;
    logic [WIN_W-1:0]  win_cnt;
    logic              busy_q;
    logic              done_q;

    logic [CNT_W-1:0]  next_count [NUM_CH];
    logic [NUM_CH-1:0] next_sat;
    logic [CNT_W-1:0]  lat_count  [NUM_CH];
    logic [NUM_CH-1:0] lat_sat;
    logic [1:0]        lat_winner;
    logic              lat_winner_valid;

    logic              cnt_en;
    logic              terminal;
    logic              do_latch;
    logic              live_clr;
    logic [1:0]        win_idx;
    logic              win_any;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spike_edge_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .spike      (mon.spike_in[g]),
            .clr        (live_clr),
            .cnt_en     (cnt_en),
            .next_count (next_count[g]),
            .next_sat   (next_sat[g])
        );
    end

    // Window control and winner of the counts about to be latched
    always_comb begin
        cnt_en   = (state == COUNT);
        terminal = (win_cnt == WIN_LAST);
        // An enable drop wins over the terminal cycle: abort, no latch
        do_latch = cnt_en && mon.enable && terminal;
        live_clr = !cnt_en || !mon.enable || terminal;

        // Strict compare keeps the lowest index on ties
        win_idx = 2'(CH_N1);
        if (next_count[CH_N2] > next_count[win_idx]) win_idx = 2'(CH_N2);
        if (next_count[CH_N3] > next_count[win_idx]) win_idx = 2'(CH_N3);
        win_any = |{next_count[CH_N1], next_count[CH_N2], next_count[CH_N3]};
    end

    // IDLE / COUNT / HOLD sequencing, window counter, busy and done strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            win_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mon.enable) begin
                        state  <= COUNT;
                        busy_q <= 1'b1;
                    end
                end
                COUNT: begin
                    if (!mon.enable) begin
                        state   <= IDLE;
                        win_cnt <= '0;
                        busy_q  <= 1'b0;
                    end else if (terminal) begin
                        win_cnt <= '0;
                        done_q  <= 1'b1;
                        if (!mon.continuous) begin
                            state  <= HOLD;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!mon.enable) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    win_cnt <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Readout registers, updated only on a completed window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_count        <= '{default: '0};
            lat_sat          <= '0;
            lat_winner       <= 2'd0;
            lat_winner_valid <= 1'b0;
        end else if (do_latch) begin
            for (int i = 0; i < NUM_CH; i++) lat_count[i] <= next_count[i];
            lat_sat          <= next_sat;
            lat_winner       <= win_idx;
            lat_winner_valid <= win_any;
        end
    end

    assign mon.count_out    = lat_count[mon.sel];
    assign mon.sat_out      = lat_sat;
    assign mon.winner       = lat_winner;
    assign mon.winner_valid = lat_winner_valid;
    assign mon.window_done  = done_q;
    assign mon.busy         = busy_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Bench for spike_rate_monitor: two instances (8-bit and 2-bit counters)
// share one stimulus stream; a window-level reference model queues the
// expected readout and a monitor checks it on every window_done.
module tb_spike_rate_monitor;
    import lif_mon_pkg::*;

    localparam int WL   = 16;
    localparam int NDUT = 2;

    typedef struct packed {
        logic [3:0][7:0] cnt;
        logic [3:0]      sat;
        logic [1:0]      win;
        logic            wv;
    } result_t;

    typedef struct packed {
        result_t a;
        result_t b;
    } pair_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] spike = 4'd0;
    logic       en    = 1'b0;
    logic       cont  = 1'b1;
    logic [1:0] sel   = 2'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_rate_monitor_if #(.CNT_W(8)) bus_a ();
    spike_rate_monitor_if #(.CNT_W(2)) bus_b ();

    assign bus_a.spike_in   = spike;
    assign bus_a.enable     = en;
    assign bus_a.continuous = cont;
    assign bus_a.sel        = sel;
    assign bus_b.spike_in   = spike;
    assign bus_b.enable     = en;
    assign bus_b.continuous = cont;
    assign bus_b.sel        = sel;

    spike_rate_monitor #(.WINDOW_LEN(WL), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .mon(bus_a)
    );
    spike_rate_monitor #(.WINDOW_LEN(WL), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .mon(bus_b)
    );

    logic [7:0] obs_cnt  [NDUT];
    logic [3:0] obs_sat  [NDUT];
    logic [1:0] obs_win  [NDUT];
    logic       obs_wv   [NDUT];
    logic       obs_done [NDUT];
    logic       obs_busy [NDUT];

    assign obs_cnt[0]  = bus_a.count_out;
    assign obs_cnt[1]  = {6'd0, bus_b.count_out};
    assign obs_sat[0]  = bus_a.sat_out;
    assign obs_sat[1]  = bus_b.sat_out;
    assign obs_win[0]  = bus_a.winner;
    assign obs_win[1]  = bus_b.winner;
    assign obs_wv[0]   = bus_a.winner_valid;
    assign obs_wv[1]   = bus_b.winner_valid;
    assign obs_done[0] = bus_a.window_done;
    assign obs_done[1] = bus_b.window_done;
    assign obs_busy[0] = bus_a.busy;
    assign obs_busy[1] = bus_b.busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Counts raw (unbounded) edges per window; saturation is applied only
    // when the window result is formed.
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;

    int         m_mode;
    int         m_k;
    logic [3:0] m_prev;
    int         raw [4];
    result_t    m_lat [NDUT];
    logic       m_done;
    logic       m_busy;
    pair_t      exp_q [$];

    function automatic result_t summarize(input int maxv);
        result_t r;
        int best;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r.cnt[i] = 8'((raw[i] > maxv) ? maxv : raw[i]);
            r.sat[i] = (raw[i] > maxv);
        end
        best = 0;
        for (int i = 1; i < 3; i++) if (r.cnt[i] > r.cnt[best]) best = i;
        r.win = 2'(best);
        r.wv  = (r.cnt[0] != 0) || (r.cnt[1] != 0) || (r.cnt[2] != 0);
        return r;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_k    = 0;
        m_prev = 4'd0;
        for (int i = 0; i < 4; i++) raw[i] = 0;
        m_lat[0] = '0;
        m_lat[1] = '0;
        m_done = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] rise;
        pair_t p;
        rise   = spike & ~m_prev;
        m_prev = spike;
        m_done = 1'b0;
        case (m_mode)
            M_IDLE: if (en) begin
                m_mode = M_RUN;
                m_k    = 0;
            end
            M_RUN: begin
                if (!en) begin
                    m_mode = M_IDLE;
                    m_k    = 0;
                    for (int i = 0; i < 4; i++) raw[i] = 0;
                end else begin
                    for (int i = 0; i < 4; i++) raw[i] += int'(rise[i]);
                    if (m_k == WL - 1) begin
                        m_lat[0] = summarize(255);
                        m_lat[1] = summarize(3);
                        p.a = m_lat[0];
                        p.b = m_lat[1];
                        exp_q.push_back(p);
                        for (int i = 0; i < 4; i++) raw[i] = 0;
                        m_k    = 0;
                        m_done = 1'b1;
                        if (!cont) m_mode = M_HOLD;
                    end else begin
                        m_k++;
                    end
                end
            end
            default: if (!en) m_mode = M_IDLE;
        endcase
        m_busy = (m_mode == M_RUN);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        pair_t   p;
        result_t r;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                check("busy", obs_busy[d], m_busy);
                check("window_done", obs_done[d], m_done);
                check("sat_out_hold", obs_sat[d], m_lat[d].sat);
                check("winner_hold", obs_win[d], m_lat[d].win);
                check("winner_valid_hold", obs_wv[d], m_lat[d].wv);
                check("count_out_hold", obs_cnt[d], m_lat[d].cnt[sel]);
            end
            if (obs_done[0] || obs_done[1]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window_done", 32'd1, 32'd0);
                end else begin
                    p = exp_q.pop_front();
                    for (int s = 0; s < 4; s++) begin
                        sel = 2'(s);
                        #1;
                        for (int d = 0; d < NDUT; d++) begin
                            r = (d == 0) ? p.a : p.b;
                            check($sformatf("win_count_d%0d_ch%0d", d, s), obs_cnt[d], r.cnt[s]);
                        end
                    end
                    for (int d = 0; d < NDUT; d++) begin
                        r = (d == 0) ? p.a : p.b;
                        check($sformatf("win_sat_d%0d", d), obs_sat[d], r.sat);
                        check($sformatf("win_winner_d%0d", d), obs_win[d], r.win);
                        check($sformatf("win_valid_d%0d", d), obs_wv[d], r.wv);
                    end
                end
            end
            sel = 2'($urandom_range(0, 3));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [3:0] v);
        spike = v;
        @(negedge clk);
    endtask

    function automatic logic [3:0] pattern(input int w, input int j);
        logic [3:0] v;
        v = 4'd0;
        case (w)
            0: begin
                v[0] = (j == 0 || j == 2 || j == 4 || j == 6 || j == 8);
                v[1] = (j == 1 || j == 3 || j == 5);
                v[3] = (j == 10 || j == 12);
            end
            1: begin
                v[0] = (j % 2 == 0) && (j < 15);
                v[2] = (j < 10) || (j == 11) || (j == 13);
            end
            2: begin
                v[1] = (j == 0 || j == 2 || j == 4 || j == 6);
                v[2] = (j == 1 || j == 3 || j == 5 || j == 7);
            end
            default: v = 4'd0;
        endcase
        return v;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("reset_count", obs_cnt[d], 32'd0);
            check("reset_winner_valid", obs_wv[d], 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back windows: basic count, level vs edge + saturation, tie, zero
        en   = 1'b1;
        cont = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < WL; j++) step(pattern(w, j));
        en = 1'b0;
        repeat (3) step(4'd0);

        // Single shot, linger in HOLD, re-arm, then abort at k=7
        cont = 1'b0;
        en   = 1'b1;
        step(4'd0);
        repeat (WL + 12) step(4'($urandom));
        en = 1'b0;
        repeat (2) step(4'd0);
        en = 1'b1;
        step(4'd0);
        repeat (7) step(4'($urandom));
        en = 1'b0;
        repeat (4) step(4'($urandom));

        // Asynchronous reset between clock edges, mid-window
        cont = 1'b1;
        en   = 1'b1;
        step(4'd0);
        repeat (5) step(4'($urandom));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("async_reset_count", obs_cnt[d], 32'd0);
            check("async_reset_sat", obs_sat[d], 32'd0);
            check("async_reset_winner", obs_win[d], 32'd0);
            check("async_reset_valid", obs_wv[d], 32'd0);
            check("async_reset_done", obs_done[d], 32'd0);
            check("async_reset_busy", obs_busy[d], 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * WL + 4) step(4'($urandom));

        // Random traffic with occasional enable and mode flips
        repeat (400) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) cont = ~cont;
            step(4'($urandom) | 4'($urandom));
        end

        en = 1'b0;
        repeat (4) step(4'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
